mem_access_unit: RTL and testbench

Initiator side of the word-wide SRAM interface, placed in the MEM stage of the DLX pipeline. It turns a single byte, halfword or word load/store request from the pipeline into SRAM cycles on `cs`/`oe`/`we`/`addr`/`din`/`dout`. The SRAM has no byte enables, so sub-word stores run as read-modify-write. The unit handles big-endian lane selection, sign extension, alignment checking, and a busy/ack handshake back to the pipeline.

---
 rtl/mem_access_unit.sv | 83 ++++++++
 tb/tb_mem_access_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator for a byte-addressed, big-endian, word-wide SRAM
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [0:31] mem_din,
  input  logic [0:31] mem_dout
);
  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, DONE, ERR} state_t;
  state_t state;
  logic [1:0] size, off;
  logic uns;
  logic [15:0] wd;
  logic [31:0] rword, lane, ext, mask, ins, merged;
  logic [4:0] sh;
  logic bad;
  // lane 0 is the most significant byte, so shifting left by 8*offset brings the addressed lane to the top
  always_comb begin
    rword = mem_dout;
    sh = {off, 3'b000};
    lane = rword << sh;
    ext = size == 2'd0 ? {{24{~uns & lane[31]}}, lane[31:24]}
        : size == 2'd1 ? {{16{~uns & lane[31]}}, lane[31:16]} : rword;
    mask = (size == 2'd0 ? 32'hff00_0000 : 32'hffff_0000) >> sh;
    ins = (size == 2'd0 ? {wd[7:0], 24'h0} : {wd, 16'h0}) >> sh;
    merged = (rword & ~mask) | (ins & mask);
    bad = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) ||
          (req_size == 2'd2 && req_addr[1:0] != 2'd0);
  end
  assign busy = state != IDLE;
  assign ack = state == DONE || state == ERR;
  assign err = state == ERR;
  assign mem_oe = state == RD || state == RMW_RD;
  assign mem_we = state == WR || state == RMW_WR;
  assign mem_cs = mem_oe | mem_we;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      size <= 2'd0;
      off <= 2'd0;
      uns <= 1'b0;
      wd <= 16'h0;
      rdata <= 32'h0;
      mem_addr <= 32'h0;
      mem_din <= 32'h0;
    end else begin
      unique case (state)
        IDLE: if (req) begin
          size <= req_size;
          off <= req_addr[1:0];
          uns <= req_unsigned;
          wd <= req_wdata[15:0];
          mem_addr <= {req_addr[31:2], 2'b00};
          if (req_we && req_size == 2'd2 && !bad) mem_din <= req_wdata;
          state <= bad ? ERR : !req_we ? RD : req_size == 2'd2 ? WR : RMW_RD;
        end
        RD: begin
          rdata <= ext;
          state <= DONE;
        end
        RMW_RD: begin
          mem_din <= merged;
          state <= RMW_WR;
        end
        WR, RMW_WR: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed loads/stores checked cycle by cycle against a lane-level model
module tb_mem_access_unit;
  logic clk = 0, rst, req, req_we, req_unsigned, preload;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, rdata, mem_addr;
  logic busy, ack, err, mem_cs, mem_oe, mem_we;
  logic [0:31] mem_din, mem_dout;
  logic [31:0] sram [0:63];
  logic [31:0] ref_mem [0:63];
  int total = 0, bad = 0;
  logic chk_on = 0;
  logic exp_busy, exp_ack, exp_err, exp_cs, exp_oe, exp_we;
  logic [31:0] exp_rdata, exp_addr, exp_din;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .ack(ack), .err(err), .rdata(rdata),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  assign mem_dout = sram[mem_addr[7:2]];
  always @(posedge clk)
    if (preload) sram <= ref_mem;
    else if (mem_cs && mem_we) sram[mem_addr[7:2]] <= mem_din;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // big-endian byte list view of a word: byte i is bits [31-8i:24-8i]
  function automatic logic [31:0] ld_model(input logic [31:0] w, input int k, input int sz, input bit u);
    int b[4];
    longint v;
    for (int i = 0; i < 4; i++) b[i] = int'((w >> (24 - 8 * i)) & 32'hff);
    if (sz == 2) return w;
    if (sz == 0) begin
      v = b[k];
      if (!u && v >= 128) v -= 256;
    end else begin
      v = b[k] * 256 + b[k + 1];
      if (!u && v >= 32768) v -= 65536;
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] st_model(input logic [31:0] w, input int k, input int sz, input logic [31:0] d);
    int b[4];
    longint r = 0;
    if (sz == 2) return d;
    for (int i = 0; i < 4; i++) b[i] = int'((w >> (24 - 8 * i)) & 32'hff);
    if (sz == 0) b[k] = int'(d & 32'hff);
    else begin
      b[k] = int'((d >> 8) & 32'hff);
      b[k + 1] = int'(d & 32'hff);
    end
    for (int i = 0; i < 4; i++) r = r * 256 + b[i];
    return 32'(r);
  endfunction

  task automatic set_exp(input logic b, input logic a, input logic e, input logic cs, input logic oe, input logic we);
    exp_busy = b; exp_ack = a; exp_err = e; exp_cs = cs; exp_oe = oe; exp_we = we;
  endtask

  always @(negedge clk)
    if (chk_on) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("ack", 32'(ack), 32'(exp_ack));
      chk("err", 32'(err), 32'(exp_err));
      chk("cs", 32'(mem_cs), 32'(exp_cs));
      chk("oe", 32'(mem_oe), 32'(exp_oe));
      chk("we", 32'(mem_we), 32'(exp_we));
      chk("oe_we_excl", 32'(mem_oe & mem_we), 32'h0);
      chk("rdata", rdata, exp_rdata);
      if (exp_cs) chk("mem_addr", mem_addr, exp_addr);
      if (exp_we) chk("mem_din", mem_din, exp_din);
    end

  // entered and left at posedge+1 of an IDLE cycle; busy cycles drive random ignored requests
  task automatic run_op(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] d);
    logic e;
    int n, idx;
    logic [31:0] old, nw;
    e = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    n = e ? 0 : (!w || sz == 2'd2) ? 1 : 2;
    idx = int'(a[7:2]);
    old = ref_mem[idx];
    nw = w ? st_model(old, int'(a[1:0]), int'(sz), d) : old;
    req = 1; req_we = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    set_exp(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= n + 1; i++) begin
      @(posedge clk); #1;
      req = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
      req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      if (i <= n) begin
        set_exp(1, 0, 0, 1, !w || (sz != 2'd2 && i == 1), w && (sz == 2'd2 || i == 2));
        exp_addr = {a[31:2], 2'b00};
        exp_din = nw;
      end else begin
        set_exp(1, 1, e, 0, 0, 0);
        if (!w && !e) exp_rdata = ld_model(old, int'(a[1:0]), int'(sz), u);
      end
    end
    @(posedge clk); #1;
    req = 0;
    set_exp(0, 0, 0, 0, 0, 0);
    if (w && !e) begin
      ref_mem[idx] = nw;
      chk("mem_word", sram[idx], nw);
    end
  endtask

  task automatic rst_rmw();
    req = 1; req_we = 1; req_size = 2'd0; req_unsigned = 0; req_addr = 32'h89; req_wdata = $urandom;
    set_exp(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    req = 0; rst = 1;
    set_exp(1, 0, 0, 1, 1, 0);
    exp_addr = 32'h88;
    @(posedge clk); #1;
    rst = 0;
    set_exp(0, 0, 0, 0, 0, 0);
    exp_rdata = 32'h0;
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    chk("rst_mem_kept", sram[34], ref_mem[34]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mem_kept2", sram[34], ref_mem[34]);
  endtask

  initial begin
    rst = 1; preload = 1; req = 1; req_we = 0; req_size = 2'd2; req_unsigned = 0;
    req_addr = 32'h80; req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[32] = 32'hF0F077F0;
    ref_mem[33] = 32'h11223344;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_ctrl", {29'h0, mem_cs, mem_oe, mem_we}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_din", mem_din, 32'h0);
    @(posedge clk); #1;
    rst = 0; preload = 0; req = 0;
    set_exp(0, 0, 0, 0, 0, 0);
    exp_rdata = 32'h0; exp_addr = 32'h0; exp_din = 32'h0;
    chk_on = 1;
    run_op(0, 2'd0, 1, 32'h80, 32'h0); chk("lbu_80", rdata, 32'h000000F0);
    run_op(0, 2'd0, 0, 32'h80, 32'h0); chk("lb_80", rdata, 32'hFFFFFFF0);
    run_op(0, 2'd0, 1, 32'h82, 32'h0); chk("lbu_82", rdata, 32'h00000077);
    run_op(0, 2'd1, 0, 32'h80, 32'h0); chk("lh_80", rdata, 32'hFFFFF0F0);
    run_op(0, 2'd1, 1, 32'h80, 32'h0); chk("lhu_80", rdata, 32'h0000F0F0);
    run_op(0, 2'd1, 0, 32'h82, 32'h0); chk("lh_82", rdata, 32'h000077F0);
    run_op(0, 2'd2, 0, 32'h80, 32'h0); chk("lw_80", rdata, 32'hF0F077F0);
    run_op(1, 2'd0, 0, 32'h81, 32'h123456AA); chk("sb_81", sram[32], 32'hF0AA77F0);
    run_op(1, 2'd1, 0, 32'h86, 32'h0000CAFE); chk("sh_86", sram[33], 32'h1122CAFE);
    run_op(1, 2'd2, 0, 32'h84, 32'hDEADBEEF); chk("sw_84", sram[33], 32'hDEADBEEF);
    run_op(0, 2'd2, 0, 32'h82, 32'h0);
    run_op(1, 2'd1, 0, 32'h83, 32'h0000BEEF);
    run_op(0, 2'd3, 0, 32'h80, 32'h0);
    chk("err_rdata_kept", rdata, 32'hF0F077F0);
    chk("err_no_write", sram[32], 32'hF0AA77F0);
    rst_rmw();
    repeat (200) begin
      run_op(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
